from8bit_deser: RTL and testbench
=================================

Name: from8bit_deser

Overview:
- Byte-to-word deserializer: accepts one 8-bit byte per enabled clock cycle and reassembles the stream into 8-, 16- or 32-bit words, selected by dataS.
- Replaces the former multi-clock arrangement (byte clock plus half- and quarter-rate word clocks) with a single clock and internal byte-phase counting.
- Sits on the receive side, downstream of the byte-lane source, and feeds the wide-word consumers.

Parameters:
- BYTE_W, 8, width of one input byte; 16-bit word = 2*BYTE_W, 32-bit word = 4*BYTE_W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- enb  input  1  clock enable; one byte is consumed per cycle with enb=1.
- dataIn  input  BYTE_W  input byte.
- dataS  input  2  mode: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- dataOut  output  BYTE_W  registered byte pass-through.
- dataOut16  output  2*BYTE_W  last completed 16-bit word.
- dataOut32  output  4*BYTE_W  last completed 32-bit word.
- valid16  output  1  one-cycle strobe: dataOut16 updated on this edge.
- valid32  output  1  one-cycle strobe: dataOut32 updated on this edge.

Behaviour:
- Reset (rst=1 at a rising edge): all outputs, the byte-phase counter cnt (2 bits), the partial-word shift register and the registered mode dataS_q are cleared to 0. Reset has priority over enb.
- enb=0: all state and outputs hold, except that valid16 and valid32 drop to 0.
- enb=1, every mode: dataOut <= dataIn (1-cycle latency).
- Mode change (dataS != dataS_q with enb=1):
  - dataS_q <= dataS and cnt is cleared.
  - The byte sampled on that edge is byte 0 of a new word.
  - Any partial word is discarded; completed-word outputs hold their old values.
- Mode 00, and reserved mode 11 (which behaves identically):
  - Only dataOut updates.
  - cnt held at 0; dataOut16 and dataOut32 hold; no strobes.
- Mode 01, packing:
  - Byte 0 is stored; cnt goes to 1.
  - On byte 1: dataOut16 <= {byte0, byte1} (first byte is the MSB, big-endian); valid16=1 for one cycle; cnt returns to 0.
- Mode 10, packing:
  - Bytes 0..3 are shifted in MSB-first.
  - On byte 3 (cnt=3): dataOut32 <= {b0, b1, b2, b3}; valid32=1 for one cycle; cnt wraps to 0.
- Strobes are registered and high only on the completing edge. Back-to-back words are allowed with no gap.
- The word outputs in inactive modes keep their last completed value.
- Reset mid-word discards the partial word; the next enabled byte is byte 0.

Decomposition:
- Shared package from8bit_pkg:
  - Mode constants MODE_8=2'b00, MODE_16=2'b01, MODE_32=2'b10, MODE_RSV=2'b11.
  - Default BYTE_W.
- One sub-module, from8bit_packer:
  - Parameters BYTE_W and LANES.
  - Shift register, lane counter, word register and strobe.
  - Instantiated with LANES=2 and LANES=4; a packer only advances when its mode is active.
  - Its clear input is driven on reset or on a mode change.

Test Plan:
- Reset then mode 00 with bytes d4, 76, d6 (enb=1) -> dataOut shows d4, 76, d6 one cycle after each; dataOut16=0, dataOut32=0, no strobes.
- Mode 01 with bytes e4, 57 -> after the second edge dataOut16=16'he457 and valid16 pulses once; bytes 12, 34 then give 16'h1234 with back-to-back strobes.
- Mode 10 with bytes 12, 34, 56, 78 -> dataOut32=32'h12345678, valid32 one cycle; dataOut16 keeps its last value.
- enb low for 3 cycles between bytes 2 and 3 in mode 10 -> no update during the gap; the word completes on the next enabled byte with the correct value.
- Mode switch 01 to 10 after a single byte aa, then bytes 01, 02, 03, 04 -> aa is discarded and dataOut32=32'h01020304.
- rst asserted after two bytes in mode 10 -> outputs 0; the next four bytes form a complete fresh word.

Source files
------------

// File: rtl/from8bit_pkg.sv
// Shared constants for the byte-to-word deserializer: mode encodings and default byte width.
package from8bit_pkg;

  localparam int DEF_BYTE_W = 8;

  localparam logic [1:0] MODE_8   = 2'b00;
  localparam logic [1:0] MODE_16  = 2'b01;
  localparam logic [1:0] MODE_32  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

endpackage

// File: rtl/from8bit_packer.sv
// Packs LANES consecutive bytes MSB-first into one word and strobes vld_o on the completing edge.
// clr_i discards any partial word. If adv_i is also high, the byte on that edge becomes byte 0.
module from8bit_packer #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    adv_i,
  input  logic [BYTE_W-1:0]       byte_i,
  output logic [LANES*BYTE_W-1:0] word_o,
  output logic                    vld_o
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = BYTE_W * (LANES - 1);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]           cnt_q, cnt_d, cnt_base;
  logic [SW-1:0]           sr_q, sr_d;
  logic [LANES*BYTE_W-1:0] word_q, word_d, ext;
  logic                    vld_q, vld_d;

  // Next-state: a clear restarts lane counting from 0. Older bytes in sr_q simply shift out.
  always_comb begin
    cnt_base = clr_i ? '0 : cnt_q;
    ext      = {sr_q, byte_i};
    cnt_d    = cnt_base;
    sr_d     = sr_q;
    word_d   = word_q;
    vld_d    = 1'b0;
    if (adv_i) begin
      if (cnt_base == LAST) begin
        word_d = ext;
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        sr_d  = ext[SW-1:0];
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  // State registers; reset clears everything, including the last completed word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o = word_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/from8bit_deser.sv
// Single-clock byte-to-word deserializer. It passes bytes through and packs them into 16- or 32-bit words.
// The word width is selected by dataS. A change of mode restarts packing with the byte on that edge.
module from8bit_deser
  import from8bit_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic [BYTE_W-1:0]   dataIn,
  input  logic [1:0]          dataS,
  output logic [BYTE_W-1:0]   dataOut,
  output logic [2*BYTE_W-1:0] dataOut16,
  output logic [4*BYTE_W-1:0] dataOut32,
  output logic                valid16,
  output logic                valid32
);

  logic [1:0]        dataS_q;
  logic [BYTE_W-1:0] dataOut_q;
  logic              mode_chg, clr, adv16, adv32;

  assign mode_chg = enb && (dataS != dataS_q);
  assign clr      = rst || mode_chg;
  assign adv16    = enb && (dataS == MODE_16);
  assign adv32    = enb && (dataS == MODE_32);

  // Registered mode and byte pass-through, both updated only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataS_q   <= MODE_8;
      dataOut_q <= '0;
    end else if (enb) begin
      dataS_q   <= dataS;
      dataOut_q <= dataIn;
    end
  end

  from8bit_packer #(.BYTE_W(BYTE_W), .LANES(2)) u_pack16 (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .adv_i  (adv16),
    .byte_i (dataIn),
    .word_o (dataOut16),
    .vld_o  (valid16)
  );

  from8bit_packer #(.BYTE_W(BYTE_W), .LANES(4)) u_pack32 (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .adv_i  (adv32),
    .byte_i (dataIn),
    .word_o (dataOut32),
    .vld_o  (valid32)
  );

  assign dataOut = dataOut_q;

endmodule

// File: tb/tb_from8bit_deser.sv
// Bench for from8bit_deser: directed scenarios plus random traffic against a queue-based word model.
module tb_from8bit_deser;

  logic        clk = 1'b0;
  logic        rst, enb;
  logic [7:0]  dataIn;
  logic [1:0]  dataS;
  logic [7:0]  dataOut;
  logic [15:0] dataOut16;
  logic [31:0] dataOut32;
  logic        valid16, valid32;

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes of the word in progress, last words, expected strobes.
  logic [7:0]  q[$];
  logic [1:0]  m_mode;
  logic [7:0]  m_out;
  logic [15:0] m_w16;
  logic [31:0] m_w32;
  logic        m_v16, m_v32;

  from8bit_deser #(.BYTE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .dataIn    (dataIn),
    .dataS     (dataS),
    .dataOut   (dataOut),
    .dataOut16 (dataOut16),
    .dataOut32 (dataOut32),
    .valid16   (valid16),
    .valid32   (valid32)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic e, input logic [1:0] md, input logic [7:0] b);
    m_v16 = 1'b0;
    m_v32 = 1'b0;
    if (r) begin
      q.delete();
      m_mode = 2'b00; m_out = '0; m_w16 = '0; m_w32 = '0;
    end else if (e) begin
      m_out = b;
      if (md != m_mode) begin
        q.delete();
        m_mode = md;
      end
      if (md == 2'b01) begin
        q.push_back(b);
        if (q.size() == 2) begin
          m_w16 = {q[0], q[1]};
          m_v16 = 1'b1;
          q.delete();
        end
      end else if (md == 2'b10) begin
        q.push_back(b);
        if (q.size() == 4) begin
          m_w32 = {q[0], q[1], q[2], q[3]};
          m_v32 = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then settle for sampling.
  task automatic step(input logic r, input logic e, input logic [1:0] md, input logic [7:0] b);
    rst = r; enb = e; dataS = md; dataIn = b;
    @(posedge clk);
    model_update(r, e, md, b);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 2'b00, 8'h00);
    total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL reset_dataOut got=%h exp=00", dataOut); end
    total++; if (dataOut16 !== 16'h0) begin bad++; $display("FAIL reset_dataOut16 got=%h exp=0000", dataOut16); end
    total++; if (dataOut32 !== 32'h0) begin bad++; $display("FAIL reset_dataOut32 got=%h exp=00000000", dataOut32); end
    total++; if ({valid16, valid32} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {valid16, valid32}); end
  endtask

  task automatic test_mode8();
    logic [7:0] bytes [3] = '{8'hd4, 8'h76, 8'hd6};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'b00, bytes[i]);
      total++; if (dataOut !== bytes[i]) begin bad++; $display("FAIL m8_dataOut[%0d] got=%h exp=%h", i, dataOut, bytes[i]); end
      total++; if (dataOut16 !== 16'h0 || dataOut32 !== 32'h0) begin bad++; $display("FAIL m8_words[%0d] got=%h/%h exp=0/0", i, dataOut16, dataOut32); end
      total++; if ({valid16, valid32} !== 2'b00) begin bad++; $display("FAIL m8_strobes[%0d] got=%b exp=00", i, {valid16, valid32}); end
    end
  endtask

  task automatic test_mode16();
    logic [7:0]  bytes [4] = '{8'he4, 8'h57, 8'h12, 8'h34};
    logic [15:0] words [2] = '{16'he457, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'b01, bytes[i]);
      total++; if (valid16 !== logic'(i % 2)) begin bad++; $display("FAIL m16_valid16[%0d] got=%b exp=%b", i, valid16, i % 2); end
      if (i % 2 == 1) begin
        total++; if (dataOut16 !== words[i/2]) begin bad++; $display("FAIL m16_word[%0d] got=%h exp=%h", i, dataOut16, words[i/2]); end
      end
      total++; if (dataOut16 !== m_w16) begin bad++; $display("FAIL m16_model[%0d] got=%h exp=%h", i, dataOut16, m_w16); end
    end
  endtask

  task automatic test_mode32();
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'b10, bytes[i]);
      total++; if (valid32 !== (i == 3)) begin bad++; $display("FAIL m32_valid32[%0d] got=%b exp=%b", i, valid32, i == 3); end
    end
    total++; if (dataOut32 !== 32'h12345678) begin bad++; $display("FAIL m32_word got=%h exp=12345678", dataOut32); end
    total++; if (dataOut16 !== 16'h1234) begin bad++; $display("FAIL m32_hold16 got=%h exp=1234", dataOut16); end
    step(1'b0, 1'b0, 2'b10, 8'hff);
    total++; if (valid32 !== 1'b0) begin bad++; $display("FAIL m32_strobe_drop got=%b exp=0", valid32); end
  endtask

  task automatic test_enb_gap();
    step(1'b0, 1'b1, 2'b10, 8'h9a);
    step(1'b0, 1'b1, 2'b10, 8'hbc);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b10, 8'h55);
      total++; if (dataOut32 !== 32'h12345678 || valid32 !== 1'b0) begin bad++; $display("FAIL gap_hold[%0d] got=%h/%b exp=12345678/0", i, dataOut32, valid32); end
      total++; if (dataOut !== 8'hbc) begin bad++; $display("FAIL gap_dataOut[%0d] got=%h exp=bc", i, dataOut); end
    end
    step(1'b0, 1'b1, 2'b10, 8'hde);
    step(1'b0, 1'b1, 2'b10, 8'hf0);
    total++; if (dataOut32 !== 32'h9abcdef0 || valid32 !== 1'b1) begin bad++; $display("FAIL gap_word got=%h/%b exp=9abcdef0/1", dataOut32, valid32); end
  endtask

  task automatic test_mode_switch();
    step(1'b0, 1'b1, 2'b01, 8'haa);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 2'b10, 8'(i));
    total++; if (dataOut32 !== 32'h01020304 || valid32 !== 1'b1) begin bad++; $display("FAIL switch_word got=%h/%b exp=01020304/1", dataOut32, valid32); end
    total++; if (dataOut16 !== 16'h1234) begin bad++; $display("FAIL switch_hold16 got=%h exp=1234", dataOut16); end
  endtask

  task automatic test_reset_midword();
    step(1'b0, 1'b1, 2'b10, 8'h11);
    step(1'b0, 1'b1, 2'b10, 8'h22);
    step(1'b1, 1'b1, 2'b10, 8'h33);
    total++; if ({dataOut, dataOut16, dataOut32} !== 56'h0) begin bad++; $display("FAIL rstmid_zero got=%h/%h/%h exp=0", dataOut, dataOut16, dataOut32); end
    step(1'b0, 1'b1, 2'b10, 8'ha1);
    step(1'b0, 1'b1, 2'b10, 8'hb2);
    step(1'b0, 1'b1, 2'b10, 8'hc3);
    total++; if (valid32 !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%b exp=0", valid32); end
    step(1'b0, 1'b1, 2'b10, 8'hd4);
    total++; if (dataOut32 !== 32'ha1b2c3d4 || valid32 !== 1'b1) begin bad++; $display("FAIL rstmid_word got=%h/%b exp=a1b2c3d4/1", dataOut32, valid32); end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [1:0] md;
    logic [7:0] b;
    md = 2'b01;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      step(r, e, md, b);
      total++;
      if (dataOut !== m_out || dataOut16 !== m_w16 || dataOut32 !== m_w32 || valid16 !== m_v16 || valid32 !== m_v32) begin
        bad++;
        $display("FAIL rand[%0d] got=%h/%h/%h/%b%b exp=%h/%h/%h/%b%b", i, dataOut, dataOut16, dataOut32, valid16, valid32,
                 m_out, m_w16, m_w32, m_v16, m_v32);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; dataS = 2'b00; dataIn = 8'h00;
    m_mode = 2'b00; m_out = '0; m_w16 = '0; m_w32 = '0; m_v16 = 1'b0; m_v32 = 1'b0;
    test_reset();
    test_mode8();
    test_mode16();
    test_mode32();
    test_enb_gap();
    test_mode_switch();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
